// File: rtl/vx_amo_rmw_unit_pkg.sv
// Shared definitions for the AMO read-modify-write unit:
// op codes, FSM states and the per-lane ALU decode.
package vx_amo_rmw_unit_pkg;

    localparam logic [4:0] INST_AMO_ADD  = 5'h00;
    localparam logic [4:0] INST_AMO_SWAP = 5'h01;
    localparam logic [4:0] INST_AMO_LR   = 5'h02;
    localparam logic [4:0] INST_AMO_SC   = 5'h03;
    localparam logic [4:0] INST_AMO_XOR  = 5'h04;
    localparam logic [4:0] INST_AMO_OR   = 5'h08;
    localparam logic [4:0] INST_AMO_AND  = 5'h0C;
    localparam logic [4:0] INST_AMO_MIN  = 5'h10;
    localparam logic [4:0] INST_AMO_MAX  = 5'h14;
    localparam logic [4:0] INST_AMO_MINU = 5'h18;
    localparam logic [4:0] INST_AMO_MAXU = 5'h1C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_ALU,
        ST_WR_REQ,
        ST_RSP
    } amo_state_e;

    typedef enum logic [2:0] {
        SEL_OLD,
        SEL_ADD,
        SEL_RS2,
        SEL_XOR,
        SEL_OR,
        SEL_AND,
        SEL_MIN,
        SEL_MAX
    } amo_sel_e;

    function automatic amo_sel_e amo_sel(input logic [4:0] op);
        amo_sel_e s;
        case (op)
            INST_AMO_ADD:  s = SEL_ADD;
            INST_AMO_SWAP: s = SEL_RS2;
            INST_AMO_XOR:  s = SEL_XOR;
            INST_AMO_OR:   s = SEL_OR;
            INST_AMO_AND:  s = SEL_AND;
            INST_AMO_MIN,
            INST_AMO_MINU: s = SEL_MIN;
            INST_AMO_MAX,
            INST_AMO_MAXU: s = SEL_MAX;
            default:       s = SEL_OLD;
        endcase
        return s;
    endfunction

    function automatic logic amo_signed(input logic [4:0] op);
        return (op == INST_AMO_MIN) || (op == INST_AMO_MAX);
    endfunction

endpackage

// File: rtl/vx_amo_rmw_unit_lane_alu.sv
// Combinational AMO datapath for one lane.
// MIN/MAX keep the old value unless rs2 strictly wins.
module vx_amo_lane_alu
    import vx_amo_rmw_unit_pkg::*;
#(
    parameter int DATAW = 32
) (
    input  logic [4:0]       op,
    input  logic [DATAW-1:0] old_data,
    input  logic [DATAW-1:0] rs2_data,
    output logic [DATAW-1:0] new_data
);

    logic             sgn;
    logic [DATAW:0]   a_x;
    logic [DATAW:0]   b_x;
    logic             b_lt;
    logic             b_gt;

    assign sgn  = amo_signed(op);
    assign a_x  = {sgn & old_data[DATAW-1], old_data};
    assign b_x  = {sgn & rs2_data[DATAW-1], rs2_data};
    assign b_lt = $signed(b_x) < $signed(a_x);
    assign b_gt = $signed(b_x) > $signed(a_x);

    always_comb begin
        new_data = old_data;
        case (amo_sel(op))
            SEL_ADD: new_data = old_data + rs2_data;
            SEL_RS2: new_data = rs2_data;
            SEL_XOR: new_data = old_data ^ rs2_data;
            SEL_OR:  new_data = old_data | rs2_data;
            SEL_AND: new_data = old_data & rs2_data;
            SEL_MIN: new_data = b_lt ? rs2_data : old_data;
            SEL_MAX: new_data = b_gt ? rs2_data : old_data;
            default: new_data = old_data;
        endcase
    end

endmodule

// File: rtl/vx_amo_rmw_unit.sv
// Atomic read-modify-write sequencer between LSU and dcache,
// one multi-lane request at a time, with an LR/SC reservation.
module vx_amo_rmw_unit
    import vx_amo_rmw_unit_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int DATAW     = 32,
    parameter int ADDRW     = 32,
    parameter int TAGW      = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [4:0]                 req_op,
    input  logic [NUM_LANES-1:0]       req_mask,
    input  logic [ADDRW-1:0]           req_addr,
    input  logic [NUM_LANES*DATAW-1:0] req_data,
    input  logic [TAGW-1:0]            req_tag,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic                       mem_req_rw,
    output logic [ADDRW-1:0]           mem_req_addr,
    output logic [NUM_LANES-1:0]       mem_req_mask,
    output logic [NUM_LANES*DATAW-1:0] mem_req_data,
    input  logic                       mem_rsp_valid,
    input  logic [NUM_LANES*DATAW-1:0] mem_rsp_data,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [NUM_LANES*DATAW-1:0] rsp_data,
    output logic [TAGW-1:0]            rsp_tag,
    output logic                       busy
);

    localparam int DW = NUM_LANES * DATAW;

    amo_state_e           state;
    amo_state_e           state_n;
    logic [4:0]           op_r;
    logic [NUM_LANES-1:0] mask_r;
    logic [ADDRW-1:0]     addr_r;
    logic [DW-1:0]        data_r;
    logic [DW-1:0]        wdata_r;
    logic [DW-1:0]        rsp_data_r;
    logic [TAGW-1:0]      tag_r;
    logic                 resv_valid;
    logic [ADDRW-1:0]     resv_addr;
    logic                 sc_ok;
    logic [DW-1:0]        old_masked;
    logic [DW-1:0]        sc_fail;
    logic [DW-1:0]        alu_out;

    assign sc_ok = resv_valid && (resv_addr == req_addr);

    always_comb begin
        old_masked = '0;
        sc_fail    = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (mask_r[i])
                old_masked[i*DATAW +: DATAW] = mem_rsp_data[i*DATAW +: DATAW];
            if (req_mask[i])
                sc_fail[i*DATAW +: DATAW] = DATAW'(1);
        end
    end

    // ALU reads the latched old value; unmasked lanes are don't-care
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        vx_amo_lane_alu #(
            .DATAW (DATAW)
        ) u_alu (
            .op       (op_r),
            .old_data (rsp_data_r[g*DATAW +: DATAW]),
            .rs2_data (data_r[g*DATAW +: DATAW]),
            .new_data (alu_out[g*DATAW +: DATAW])
        );
    end

    always_comb begin
        state_n       = state;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        rsp_valid     = 1'b0;
        busy          = 1'b1;
        unique case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid)
                    state_n = (req_op == INST_AMO_SC && !sc_ok)
                            ? ST_RSP : ST_RD_REQ;
            end
            ST_RD_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready)
                    state_n = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (mem_rsp_valid) begin
                    if (op_r == INST_AMO_LR)
                        state_n = ST_RSP;
                    else if (op_r == INST_AMO_SC)
                        state_n = ST_WR_REQ;
                    else
                        state_n = ST_ALU;
                end
            end
            ST_ALU: state_n = ST_WR_REQ;
            ST_WR_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                if (mem_req_ready)
                    state_n = ST_RSP;
            end
            ST_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_r       <= '0;
            mask_r     <= '0;
            addr_r     <= '0;
            data_r     <= '0;
            wdata_r    <= '0;
            rsp_data_r <= '0;
            tag_r      <= '0;
            resv_valid <= 1'b0;
            resv_addr  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_r   <= req_op;
                        mask_r <= req_mask;
                        addr_r <= req_addr;
                        data_r <= req_data;
                        tag_r  <= req_tag;
                        if (req_op == INST_AMO_SC && !sc_ok)
                            rsp_data_r <= sc_fail;
                    end
                end
                ST_RD_WAIT: begin
                    if (mem_rsp_valid) begin
                        if (op_r == INST_AMO_SC) begin
                            rsp_data_r <= '0;
                            wdata_r    <= data_r;
                        end else begin
                            rsp_data_r <= old_masked;
                        end
                        if (op_r == INST_AMO_LR) begin
                            resv_valid <= 1'b1;
                            resv_addr  <= addr_r;
                        end
                    end
                end
                ST_ALU: wdata_r <= alu_out;
                ST_WR_REQ: begin
                    if (mem_req_ready && resv_addr == addr_r)
                        resv_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign mem_req_addr = addr_r;
    assign mem_req_mask = mask_r;
    assign mem_req_data = wdata_r;
    assign rsp_data     = rsp_data_r;
    assign rsp_tag      = tag_r;

endmodule

// File: doc/vx_amo_rmw_unit.md
Name: vx_amo_rmw_unit

Overview:
- Sequences a complete atomic read-modify-write for one request at a time, with multi-lane support.
- Flow: accept request, issue memory read, compute the AMO per lane in a registered ALU stage, issue memory write-back, return the old memory value to the requester.
- Supports LR/SC through a single reservation register.
- Sits between the LSU issue path and the data-cache memory port.

Parameters:
- NUM_LANES, 4: SIMD lanes per request.
- DATAW, 32: lane width in bits; 32 or 64.
- ADDRW, 32: byte address width.
- TAGW, 8: opaque request tag, returned unchanged.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  high only in IDLE.
- req_op  in  5  INST_AMO_* code (ADD, SWAP, XOR, OR, AND, MIN, MAX, MINU, MAXU, LR, SC).
- req_mask  in  NUM_LANES  active-lane mask.
- req_addr  in  ADDRW  line-aligned base address.
- req_data  in  NUM_LANES*DATAW  rs2 operand per lane.
- req_tag  in  TAGW  requester tag.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory request accepted.
- mem_req_rw  out  1  0 = read, 1 = write.
- mem_req_addr  out  ADDRW  request address.
- mem_req_mask  out  NUM_LANES  lane write/read enable.
- mem_req_data  out  NUM_LANES*DATAW  write data.
- mem_rsp_valid  in  1  read data valid; always accepted.
- mem_rsp_data  in  NUM_LANES*DATAW  read data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_data  out  NUM_LANES*DATAW  old memory value (LR/AMO) or SC status.
- rsp_tag  out  TAGW  echoed tag.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert): FSM=IDLE; all valids 0; rsp_data, rsp_tag, mem_req_* data/address outputs 0; reservation invalid.
- FSM states: IDLE, RD_REQ, RD_WAIT, ALU, WR_REQ, RSP.
- IDLE: on req_valid & req_ready, latch op, mask, addr, data and tag, then go to RD_REQ.
  - Exception: SC with no reservation, or reservation address ≠ req_addr, goes directly to RSP with rsp_data lane = 1 (fail) for every masked lane.
- RD_REQ: mem_req_valid=1, rw=0. Hold all fields stable until mem_req_ready, then go to RD_WAIT.
- RD_WAIT: wait for mem_rsp_valid and latch old data.
  - LR: set reservation to addr, go to RSP.
  - SC (reservation matched): go to WR_REQ; write data = req_data; rsp_data = 0 (success); reservation cleared.
  - Otherwise: go to ALU.
- ALU: one cycle, registered. Per masked lane, new = f(old, rs2):
  - ADD: wraps mod 2^DATAW.
  - SWAP: rs2.
  - XOR / OR / AND: bitwise.
  - MIN/MAX: signed compare on a (DATAW+1)-bit sign-extended value.
  - MINU/MAXU: zero-extended compare.
  - Equal operands: MIN/MAX return old.
  - Unknown op: new = old. The write still occurs and is harmless.
- WR_REQ: mem_req_valid=1, rw=1, mask=latched mask. Go to RSP on mem_req_ready.
- RSP: rsp_valid=1; rsp_data = old value per lane, except SC, which returns status. Unmasked lanes are 0. Hold until rsp_ready, then go to IDLE.
- Latencies:
  - Minimum request-to-response with zero memory stall: 5 cycles (RD_REQ, RD_WAIT with same-cycle response in the following cycle, ALU, WR_REQ, RSP).
  - req_ready returns high the cycle after the rsp handshake.
- Reservation:
  - Any AMO or SC write to the reserved address clears it.
  - LR overwrites it.
  - Reset clears it.
- mem_rsp_valid outside RD_WAIT is ignored.
- An all-zero mask still completes the full sequence with a zero write mask.

Decomposition:
- Shared package holds:
  - AMO op codes (existing INST_AMO_* plus LR/SC).
  - FSM state enum.
  - Lane ALU function.
- One sub-module: vx_amo_lane_alu, purely combinational, DATAW-parametrised, instantiated NUM_LANES times via generate. The parent registers its output in the ALU state.

Test Plan:
- AMOADD, NUM_LANES=4, mask=4'b1111, mem=[1,2,3,0xFFFFFFFF], rs2=[1,1,1,1] → write [2,3,4,0], rsp_data=[1,2,3,0xFFFFFFFF], rsp after 5 cycles with no stalls.
- AMOMIN vs AMOMINU with old=0x80000000, rs2=1 → MIN writes 0x80000000; MINU writes 1; both return 0x80000000.
- LR to A, then SC to A with data 0x55 → SC writes 0x55 and returns 0. A second SC to A → no memory traffic, returns 1.
- mem_req_ready held low 10 cycles in RD_REQ and WR_REQ, plus rsp_ready low 3 cycles → outputs stable throughout; req_ready low until the rsp handshake.
- reset asserted in WR_REQ mid-stall → mem_req_valid drops immediately; FSM returns to IDLE; reservation cleared; the next request completes normally.
- mask=4'b0101 AMOSWAP → mem_req_mask=0101; rsp_data lanes 1 and 3 are 0.
